// File: rtl/vlsu_axi_req_sched.sv
// VLSU address-channel scheduler: round-robin load/store arbitration onto one
// issue slot driving AXI AR/AW, with per-direction outstanding-burst credits.
module vlsu_axi_req_sched #(
    parameter int unsigned AxiAddrWidth = 64,
    parameter int unsigned MaxLdBursts  = 8,
    parameter int unsigned MaxStBursts  = 8,
    parameter int unsigned CntW         =
        $clog2(((MaxLdBursts > MaxStBursts) ? MaxLdBursts : MaxStBursts) + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    ld_req_valid_i,
    output logic                    ld_req_ready_o,
    input  logic [AxiAddrWidth-1:0] ld_req_addr_i,
    input  logic [7:0]              ld_req_len_i,
    input  logic                    st_req_valid_i,
    output logic                    st_req_ready_o,
    input  logic [AxiAddrWidth-1:0] st_req_addr_i,
    input  logic [7:0]              st_req_len_i,
    output logic                    ar_valid_o,
    input  logic                    ar_ready_i,
    output logic [AxiAddrWidth-1:0] ar_addr_o,
    output logic [7:0]              ar_len_o,
    output logic                    aw_valid_o,
    input  logic                    aw_ready_i,
    output logic [AxiAddrWidth-1:0] aw_addr_o,
    output logic [7:0]              aw_len_o,
    input  logic                    r_last_hs_i,
    input  logic                    b_hs_i,
    input  logic                    core_st_pending_i,
    output logic [CntW-1:0]         ld_outstanding_o,
    output logic [CntW-1:0]         st_outstanding_o,
    output logic                    store_pending_o,
    output logic                    idle_o
);

    typedef enum logic [1:0] {
        IDLE,
        AR_ISSUE,
        AW_ISSUE
    } state_e;

    typedef enum logic {
        SIDE_LD,
        SIDE_ST
    } side_e;

    state_e                  state_q;
    side_e                   rr_last_q;
    logic [AxiAddrWidth-1:0] slot_addr_q;
    logic [7:0]              slot_len_q;
    logic                    ar_valid_q;
    logic                    aw_valid_q;
    logic [CntW-1:0]         ld_cnt_q;
    logic [CntW-1:0]         st_cnt_q;
    logic [CntW-1:0]         ld_cnt_d;
    logic [CntW-1:0]         st_cnt_d;

    logic ld_elig;
    logic st_elig;
    logic ld_grant;
    logic st_grant;
    logic ar_hs;
    logic aw_hs;

    always_comb begin
        ld_elig  = (state_q == IDLE) && ld_req_valid_i && !core_st_pending_i
                   && (ld_cnt_q < CntW'(MaxLdBursts));
        st_elig  = (state_q == IDLE) && st_req_valid_i
                   && (st_cnt_q < CntW'(MaxStBursts));
        // On a tie the side that did not win last time goes first.
        ld_grant = ld_elig && (!st_elig || (rr_last_q == SIDE_ST));
        st_grant = st_elig && !ld_grant;
        ar_hs    = ar_valid_q && ar_ready_i;
        aw_hs    = aw_valid_q && aw_ready_i;
    end

    // A retire at zero is dropped so the counter cannot wrap.
    always_comb begin
        ld_cnt_d = ld_cnt_q;
        unique case ({ar_hs, r_last_hs_i})
            2'b10:   ld_cnt_d = ld_cnt_q + CntW'(1);
            2'b01:   ld_cnt_d = (ld_cnt_q != '0) ? ld_cnt_q - CntW'(1) : ld_cnt_q;
            default: ld_cnt_d = ld_cnt_q;
        endcase
        st_cnt_d = st_cnt_q;
        unique case ({aw_hs, b_hs_i})
            2'b10:   st_cnt_d = st_cnt_q + CntW'(1);
            2'b01:   st_cnt_d = (st_cnt_q != '0) ? st_cnt_q - CntW'(1) : st_cnt_q;
            default: st_cnt_d = st_cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            rr_last_q   <= SIDE_ST;
            slot_addr_q <= '0;
            slot_len_q  <= '0;
            ar_valid_q  <= 1'b0;
            aw_valid_q  <= 1'b0;
            ld_cnt_q    <= '0;
            st_cnt_q    <= '0;
        end else begin
            ld_cnt_q <= ld_cnt_d;
            st_cnt_q <= st_cnt_d;
            unique case (state_q)
                IDLE: begin
                    if (ld_grant) begin
                        state_q     <= AR_ISSUE;
                        rr_last_q   <= SIDE_LD;
                        slot_addr_q <= ld_req_addr_i;
                        slot_len_q  <= ld_req_len_i;
                        ar_valid_q  <= 1'b1;
                    end else if (st_grant) begin
                        state_q     <= AW_ISSUE;
                        rr_last_q   <= SIDE_ST;
                        slot_addr_q <= st_req_addr_i;
                        slot_len_q  <= st_req_len_i;
                        aw_valid_q  <= 1'b1;
                    end
                end
                AR_ISSUE: begin
                    if (ar_ready_i) begin
                        state_q    <= IDLE;
                        ar_valid_q <= 1'b0;
                    end
                end
                AW_ISSUE: begin
                    if (aw_ready_i) begin
                        state_q    <= IDLE;
                        aw_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    ar_valid_q <= 1'b0;
                    aw_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign ld_req_ready_o   = ld_grant;
    assign st_req_ready_o   = st_grant;
    assign ar_valid_o       = ar_valid_q;
    assign aw_valid_o       = aw_valid_q;
    assign ar_addr_o        = slot_addr_q;
    assign ar_len_o         = slot_len_q;
    assign aw_addr_o        = slot_addr_q;
    assign aw_len_o         = slot_len_q;
    assign ld_outstanding_o = ld_cnt_q;
    assign st_outstanding_o = st_cnt_q;
    assign store_pending_o  = st_req_valid_i || (state_q == AW_ISSUE) || (st_cnt_q != '0);
    assign idle_o           = (state_q == IDLE) && (ld_cnt_q == '0) && (st_cnt_q == '0);

`ifndef SYNTHESIS
    ld_retire_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(r_last_hs_i && !ar_hs && (ld_cnt_q == '0)));
    st_retire_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(b_hs_i && !aw_hs && (st_cnt_q == '0)));
    ar_aw_exclusive: assert property (@(posedge clk_i) disable iff (rst_i)
        !(ar_valid_q && aw_valid_q));
`endif

endmodule

// File: tb/tb_vlsu_axi_req_sched.sv
// Bench for vlsu_axi_req_sched: vector table, directed corner sequences, and
// randomized traffic against a transaction-level reference model.
module tb_vlsu_axi_req_sched;

    localparam int unsigned AW   = 32;
    localparam int          MAXL = 2;
    localparam int          MAXS = 4;

    logic          clk = 1'b0;
    logic          rst, ld_v, st_v, core, ar_rdy, aw_rdy, rl, b;
    logic [AW-1:0] la, sa;
    logic [7:0]    ll, sl;
    logic          ld_rdy, st_rdy, arv, awv, sp, idle;
    logic [AW-1:0] ar_addr, aw_addr;
    logic [7:0]    ar_len, aw_len;
    logic [2:0]    ldo, sto;

    int n_checks = 0;
    int n_err    = 0;

    vlsu_axi_req_sched #(
        .AxiAddrWidth(AW),
        .MaxLdBursts (MAXL),
        .MaxStBursts (MAXS)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .ld_req_valid_i   (ld_v),
        .ld_req_ready_o   (ld_rdy),
        .ld_req_addr_i    (la),
        .ld_req_len_i     (ll),
        .st_req_valid_i   (st_v),
        .st_req_ready_o   (st_rdy),
        .st_req_addr_i    (sa),
        .st_req_len_i     (sl),
        .ar_valid_o       (arv),
        .ar_ready_i       (ar_rdy),
        .ar_addr_o        (ar_addr),
        .ar_len_o         (ar_len),
        .aw_valid_o       (awv),
        .aw_ready_i       (aw_rdy),
        .aw_addr_o        (aw_addr),
        .aw_len_o         (aw_len),
        .r_last_hs_i      (rl),
        .b_hs_i           (b),
        .core_st_pending_i(core),
        .ld_outstanding_o (ldo),
        .st_outstanding_o (sto),
        .store_pending_o  (sp),
        .idle_o           (idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rst, ld_v, st_v, core, ar_rdy, aw_rdy, rl, b;
        logic [AW-1:0] la, sa;
        logic [7:0] ll, sl;
        bit e_ldr, e_str, e_arv, e_awv;
        int e_ldo, e_sto;
        bit e_sp, e_idle;
        logic [AW-1:0] e_addr;
        logic [7:0] e_len;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input bit ldr, str, e_arv, e_awv,
                              input int e_ldo, e_sto, input bit e_sp, e_idle,
                              input logic [AW-1:0] ea, input logic [7:0] el);
        chk({tag, " ld_ready"}, 64'(ld_rdy), 64'(ldr));
        chk({tag, " st_ready"}, 64'(st_rdy), 64'(str));
        chk({tag, " ar_valid"}, 64'(arv), 64'(e_arv));
        chk({tag, " aw_valid"}, 64'(awv), 64'(e_awv));
        chk({tag, " ld_outstanding"}, 64'(ldo), 64'(e_ldo));
        chk({tag, " st_outstanding"}, 64'(sto), 64'(e_sto));
        chk({tag, " store_pending"}, 64'(sp), 64'(e_sp));
        chk({tag, " idle"}, 64'(idle), 64'(e_idle));
        if (e_arv) begin
            chk({tag, " ar_addr"}, 64'(ar_addr), 64'(ea));
            chk({tag, " ar_len"}, 64'(ar_len), 64'(el));
        end
        if (e_awv) begin
            chk({tag, " aw_addr"}, 64'(aw_addr), 64'(ea));
            chk({tag, " aw_len"}, 64'(aw_len), 64'(el));
        end
    endtask

    task automatic clear_inputs();
        rst = 0; ld_v = 0; st_v = 0; core = 0; ar_rdy = 0; aw_rdy = 0; rl = 0; b = 0;
        la = '0; sa = '0; ll = '0; sl = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1;
        @(negedge clk);
        rst = 0;
    endtask

    function automatic vec_t mk(bit r, lv, sv, c, arr, awr, rlast, bh,
                                logic [AW-1:0] a_l, logic [7:0] l_l, logic [AW-1:0] a_s, logic [7:0] l_s,
                                bit ldr, str, e_arv, e_awv, int e_ldo, int e_sto, bit e_sp, bit e_idle,
                                logic [AW-1:0] ea, logic [7:0] el);
        vec_t v;
        v.rst = r; v.ld_v = lv; v.st_v = sv; v.core = c; v.ar_rdy = arr; v.aw_rdy = awr;
        v.rl = rlast; v.b = bh; v.la = a_l; v.ll = l_l; v.sa = a_s; v.sl = l_s;
        v.e_ldr = ldr; v.e_str = str; v.e_arv = e_arv; v.e_awv = e_awv;
        v.e_ldo = e_ldo; v.e_sto = e_sto; v.e_sp = e_sp; v.e_idle = e_idle;
        v.e_addr = ea; v.e_len = el;
        return v;
    endfunction

    // Reference model state: busy 0=slot empty, 1=load in slot, 2=store in slot.
    int            m_busy, m_ld, m_st;
    bit            m_last_ld;
    logic [AW-1:0] m_addr;
    logic [7:0]    m_len;
    bit            ld_ok, st_ok, gl, gs;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;

        // rst ldv stv core arr awr rl b | la ll sa sl | ldr str arv awv ldo sto sp idle | addr len
        vecs.push_back(mk(0,1,0,0,1,0,0,0, 'h1000,3,0,0,       1,0,0,0, 0,0, 0,1, 0,0));
        vecs.push_back(mk(0,0,0,0,1,0,0,0, 'h1000,3,0,0,       0,0,1,0, 0,0, 0,0, 'h1000,3));
        vecs.push_back(mk(0,0,0,0,1,0,0,0, 0,0,0,0,            0,0,0,0, 1,0, 0,0, 0,0));
        vecs.push_back(mk(0,0,0,0,1,0,1,0, 0,0,0,0,            0,0,0,0, 1,0, 0,0, 0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,            0,0,0,0, 0,0, 0,1, 0,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,0,            0,0,0,0, 0,0, 0,1, 0,0));
        vecs.push_back(mk(0,1,1,0,1,1,0,0, 'h2000,1,'h3000,2,  1,0,0,0, 0,0, 1,1, 0,0));
        vecs.push_back(mk(0,1,1,0,1,1,0,0, 'h2000,1,'h3000,2,  0,0,1,0, 0,0, 1,0, 'h2000,1));
        vecs.push_back(mk(0,1,1,0,1,1,0,0, 'h2000,1,'h3000,2,  0,1,0,0, 1,0, 1,0, 0,0));
        vecs.push_back(mk(0,1,1,0,1,1,0,0, 'h2000,1,'h3000,2,  0,0,0,1, 1,0, 1,0, 'h3000,2));
        vecs.push_back(mk(0,1,1,0,1,1,0,0, 'h2000,1,'h3000,2,  1,0,0,0, 1,1, 1,0, 0,0));
        vecs.push_back(mk(0,1,1,0,1,1,0,0, 'h2000,1,'h3000,2,  0,0,1,0, 1,1, 1,0, 'h2000,1));
        vecs.push_back(mk(0,1,1,0,1,1,0,0, 'h2000,1,'h3000,2,  0,1,0,0, 2,1, 1,0, 0,0));
        vecs.push_back(mk(0,1,1,0,1,1,0,0, 'h2000,1,'h3000,2,  0,0,0,1, 2,1, 1,0, 'h3000,2));
        vecs.push_back(mk(0,1,1,0,1,1,0,0, 'h2000,1,'h3000,2,  0,1,0,0, 2,2, 1,0, 0,0));
        vecs.push_back(mk(0,1,0,0,1,1,0,0, 'h2000,1,'h3000,2,  0,0,0,1, 2,2, 1,0, 'h3000,2));
        vecs.push_back(mk(0,1,0,0,1,1,1,0, 'h2000,1,'h3000,2,  0,0,0,0, 2,3, 1,0, 0,0));
        vecs.push_back(mk(0,1,0,0,1,1,0,0, 'h2000,1,'h3000,2,  1,0,0,0, 1,3, 1,0, 0,0));
        vecs.push_back(mk(0,0,0,0,1,1,1,0, 'h2000,1,'h3000,2,  0,0,1,0, 1,3, 1,0, 'h2000,1));
        vecs.push_back(mk(0,0,0,0,1,1,0,0, 'h2000,1,'h3000,2,  0,0,0,0, 1,3, 1,0, 0,0));
        vecs.push_back(mk(0,1,1,1,1,1,0,0, 'h2000,1,'h3000,2,  0,1,0,0, 1,3, 1,0, 0,0));
        vecs.push_back(mk(0,1,0,1,1,1,0,0, 'h2000,1,'h3000,2,  0,0,0,1, 1,3, 1,0, 'h3000,2));
        vecs.push_back(mk(0,1,0,1,1,1,0,0, 'h2000,1,'h3000,2,  0,0,0,0, 1,4, 1,0, 0,0));
        vecs.push_back(mk(0,1,0,0,1,1,0,0, 'h2000,1,'h3000,2,  1,0,0,0, 1,4, 1,0, 0,0));
        vecs.push_back(mk(0,0,0,0,1,1,0,0, 'h2000,1,'h3000,2,  0,0,1,0, 1,4, 1,0, 'h2000,1));
        vecs.push_back(mk(0,0,0,0,1,1,0,0, 'h2000,1,'h3000,2,  0,0,0,0, 2,4, 1,0, 0,0));

        do_reset();
        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; ld_v = vecs[i].ld_v; st_v = vecs[i].st_v; core = vecs[i].core;
            ar_rdy = vecs[i].ar_rdy; aw_rdy = vecs[i].aw_rdy; rl = vecs[i].rl; b = vecs[i].b;
            la = vecs[i].la; ll = vecs[i].ll; sa = vecs[i].sa; sl = vecs[i].sl;
            #1;
            check_outs($sformatf("row%0d", i), vecs[i].e_ldr, vecs[i].e_str, vecs[i].e_arv,
                       vecs[i].e_awv, vecs[i].e_ldo, vecs[i].e_sto, vecs[i].e_sp,
                       vecs[i].e_idle, vecs[i].e_addr, vecs[i].e_len);
        end

        // AR back-pressure: slot must hold while the load input changes underneath.
        do_reset();
        @(negedge clk);
        ld_v = 1; la = 'hABC0; ll = 7; ar_rdy = 0;
        #1 check_outs("stall grant", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            ld_v = 1; st_v = 1; la = 'hFFFF0; ll = 8'hEE; sa = 'h5550; sl = 4;
            #1 check_outs($sformatf("stall%0d", k), 0, 0, 1, 0, 0, 0, 1, 0, 'hABC0, 7);
        end
        @(negedge clk);
        ld_v = 0; st_v = 0; ar_rdy = 1;
        #1 check_outs("stall hs", 0, 0, 1, 0, 0, 0, 0, 0, 'hABC0, 7);
        @(negedge clk);
        ar_rdy = 0;
        #1 check_outs("stall after", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

        // Reset while a store sits in AW_ISSUE with three stores outstanding.
        do_reset();
        aw_rdy = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            st_v = 1; sa = AW'(k * 'h100 + 'h40); sl = 2;
            #1 check_outs($sformatf("st%0d grant", k), 0, 1, 0, 0, 0, k, 1, k == 0, 0, 0);
            @(negedge clk);
            st_v = 0;
            #1 check_outs($sformatf("st%0d issue", k), 0, 0, 0, 1, 0, k, 1, 0, AW'(k * 'h100 + 'h40), 2);
        end
        @(negedge clk);
        st_v = 1; sa = 'h9000; aw_rdy = 0;
        #1 check_outs("st3 grant", 0, 1, 0, 0, 0, 3, 1, 0, 0, 0);
        @(negedge clk);
        st_v = 0; rst = 1;
        #1 check_outs("st3 in reset", 0, 0, 0, 1, 0, 3, 1, 0, 'h9000, 2);
        @(negedge clk);
        rst = 0;
        #1 check_outs("post reset", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        // Random traffic against the reference model.
        do_reset();
        m_busy = 0; m_ld = 0; m_st = 0; m_last_ld = 0; m_addr = '0; m_len = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst    = ($urandom_range(0, 99) == 0);
            ld_v   = ($urandom_range(0, 9) < 7);
            st_v   = ($urandom_range(0, 9) < 6);
            core   = ($urandom_range(0, 9) < 2);
            ar_rdy = ($urandom_range(0, 9) < 6);
            aw_rdy = ($urandom_range(0, 9) < 6);
            rl     = (m_ld > 0) && ($urandom_range(0, 9) < 3);
            b      = (m_st > 0) && ($urandom_range(0, 9) < 3);
            la = AW'($urandom); ll = 8'($urandom);
            sa = AW'($urandom); sl = 8'($urandom);

            ld_ok = ld_v && !core && (m_ld < MAXL);
            st_ok = st_v && (m_st < MAXS);
            gl    = (m_busy == 0) && ld_ok && (!st_ok || !m_last_ld);
            gs    = (m_busy == 0) && st_ok && !gl;
            #1;
            check_outs("rand", gl, gs, m_busy == 1, m_busy == 2, m_ld, m_st,
                       st_v || (m_busy == 2) || (m_st != 0),
                       (m_busy == 0) && (m_ld == 0) && (m_st == 0), m_addr, m_len);

            if (rst) begin
                m_busy = 0; m_ld = 0; m_st = 0; m_last_ld = 0; m_addr = '0; m_len = '0;
            end else begin
                m_ld = m_ld + ((m_busy == 1 && ar_rdy) ? 1 : 0) - (rl ? 1 : 0);
                m_st = m_st + ((m_busy == 2 && aw_rdy) ? 1 : 0) - (b ? 1 : 0);
                if (m_ld < 0) m_ld = 0;
                if (m_st < 0) m_st = 0;
                if (m_busy == 0) begin
                    if (gl) begin
                        m_busy = 1; m_addr = la; m_len = ll; m_last_ld = 1;
                    end else if (gs) begin
                        m_busy = 2; m_addr = sa; m_len = sl; m_last_ld = 0;
                    end
                end else if ((m_busy == 1 && ar_rdy) || (m_busy == 2 && aw_rdy)) begin
                    m_busy = 0;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
